// File: rtl/yoda_ima_pkg.sv
// Shared defaults and FSM encoding for the pixel stream scanner.
package yoda_ima_pkg;

    localparam int DEF_IMG_W = 320;
    localparam int DEF_IMG_H = 240;
    localparam int DEF_PIX_W = 12;

    typedef logic [1:0] scan_state_t;

    localparam scan_state_t ST_IDLE  = 2'd0;
    localparam scan_state_t ST_RUN   = 2'd1;
    localparam scan_state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/pixel_stream_scanner_scan_counter.sv
// Row/column raster counter with end-of-row and end-of-frame flags.
module scan_counter
    import yoda_ima_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int COL_W = 9,
    parameter int ROW_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last_col,
    output logic             last_addr
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    always_comb begin
        last_col  = (col_q == COL_W'(IMG_W - 1));
        last_addr = last_col && (row_q == ROW_W'(IMG_H - 1));
        row_d     = row_q;
        col_d     = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (step) begin
            // Wrap to (0,0) after the last address; the FSM decides whether it is used.
            if (last_col) begin
                col_d = '0;
                row_d = last_addr ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row = row_q;
    assign col = col_q;

endmodule

// File: rtl/pixel_stream_scanner.sv
// Raster-scans a pixel ROM and streams pixels over a valid/ready handshake.
// Optional SCAN_CHECKSUM_EN adds frame_sum, the XOR of each completed frame.
module pixel_stream_scanner
    import yoda_ima_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int PIX_W = DEF_PIX_W,
    parameter int COL_W = 9,
    parameter int ROW_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    output logic [ROW_W-1:0] rom_row,
    output logic [COL_W-1:0] rom_col,
    input  logic [PIX_W-1:0] rom_data,
    output logic [PIX_W-1:0] pixel_out,
    output logic [ROW_W-1:0] pix_row,
    output logic [COL_W-1:0] pix_col,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sof,
    output logic             eol,
    output logic             eof,
    output logic             busy,
    output logic             frame_done
`ifdef SCAN_CHECKSUM_EN
    ,
    output logic [PIX_W-1:0] frame_sum
`endif
);

    scan_state_t state_q, state_d;
    logic stall, issue, xfer, eof_xfer, cnt_clear;
    logic [ROW_W-1:0] cnt_row;
    logic [COL_W-1:0] cnt_col;
    logic last_col, last_addr;

    logic             s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d;
    logic             s1_eol_q, s1_eol_d, s1_eof_q, s1_eof_d;
    logic [ROW_W-1:0] s1_row_q, s1_row_d;
    logic [COL_W-1:0] s1_col_q, s1_col_d;

    logic [PIX_W-1:0] pix_q, pix_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic valid_q, valid_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
    logic done_q, done_d;

    scan_counter #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .COL_W(COL_W),
        .ROW_W(ROW_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .step     (issue),
        .row      (cnt_row),
        .col      (cnt_col),
        .last_col (last_col),
        .last_addr(last_addr)
    );

    always_comb begin
        stall     = valid_q && !out_ready;
        xfer      = valid_q && out_ready;
        eof_xfer  = xfer && eof_q;
        issue     = (state_q == ST_RUN) && !stall;
        cnt_clear = (state_q == ST_IDLE) && start;

        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (issue && last_addr && !continuous) state_d = ST_DRAIN;
            ST_DRAIN: if (eof_xfer) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // While stalled, re-address the stage-1 pixel so rom_data is valid on release.
        rom_row = stall ? s1_row_q : cnt_row;
        rom_col = stall ? s1_col_q : cnt_col;

        s1_valid_d = s1_valid_q;
        s1_row_d   = s1_row_q;
        s1_col_d   = s1_col_q;
        s1_sof_d   = s1_sof_q;
        s1_eol_d   = s1_eol_q;
        s1_eof_d   = s1_eof_q;
        pix_d      = pix_q;
        row_d      = row_q;
        col_d      = col_q;
        valid_d    = valid_q;
        sof_d      = sof_q;
        eol_d      = eol_q;
        eof_d      = eof_q;
        if (!stall) begin
            s1_valid_d = issue;
            s1_row_d   = cnt_row;
            s1_col_d   = cnt_col;
            s1_sof_d   = issue && (cnt_row == '0) && (cnt_col == '0);
            s1_eol_d   = issue && last_col;
            s1_eof_d   = issue && last_addr;
            pix_d      = rom_data;
            row_d      = s1_row_q;
            col_d      = s1_col_q;
            valid_d    = s1_valid_q;
            sof_d      = s1_sof_q;
            eol_d      = s1_eol_q;
            eof_d      = s1_eof_q;
        end
        done_d = eof_xfer;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            s1_valid_q <= 1'b0;
            s1_row_q   <= '0;
            s1_col_q   <= '0;
            s1_sof_q   <= 1'b0;
            s1_eol_q   <= 1'b0;
            s1_eof_q   <= 1'b0;
            pix_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            eof_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_row_q   <= s1_row_d;
            s1_col_q   <= s1_col_d;
            s1_sof_q   <= s1_sof_d;
            s1_eol_q   <= s1_eol_d;
            s1_eof_q   <= s1_eof_d;
            pix_q      <= pix_d;
            row_q      <= row_d;
            col_q      <= col_d;
            valid_q    <= valid_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
            eof_q      <= eof_d;
            done_q     <= done_d;
        end
    end

    assign pixel_out  = pix_q;
    assign pix_row    = row_q;
    assign pix_col    = col_q;
    assign out_valid  = valid_q;
    assign sof        = sof_q;
    assign eol        = eol_q;
    assign eof        = eof_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = done_q;

`ifdef SCAN_CHECKSUM_EN
    logic [PIX_W-1:0] acc_q, acc_d, sum_q, sum_d;

    always_comb begin
        acc_d = acc_q;
        sum_d = sum_q;
        if (xfer) begin
            acc_d = acc_q ^ pix_q;
            if (eof_q) begin
                sum_d = acc_d;
                acc_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            sum_q <= '0;
        end else begin
            acc_q <= acc_d;
            sum_q <= sum_d;
        end
    end

    assign frame_sum = sum_q;
`endif

endmodule

// File: tb/tb_pixel_stream_scanner.sv
// Directed scoreboard bench for pixel_stream_scanner on a 4x3 image.
module tb_pixel_stream_scanner;

    localparam int IMG_W = 4;
    localparam int IMG_H = 3;
    localparam int PIX_W = 12;
    localparam int COL_W = 3;
    localparam int ROW_W = 2;

    typedef struct packed {
        logic [PIX_W-1:0] pix;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [2:0]       flags;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             continuous = 1'b0;
    logic             out_ready = 1'b1;
    logic [ROW_W-1:0] rom_row, pix_row;
    logic [COL_W-1:0] rom_col, pix_col;
    logic [PIX_W-1:0] rom_data = '0;
    logic [PIX_W-1:0] pixel_out;
    logic             out_valid, sof, eol, eof, busy, frame_done;
`ifdef SCAN_CHECKSUM_EN
    logic [PIX_W-1:0] frame_sum;
`endif

    logic [PIX_W-1:0] rom_ofs = '0;
    exp_t             exp_q[$];
    logic [PIX_W-1:0] sum_q[$];
    int               checks = 0;
    int               errors = 0;
    int               fd_count = 0;
    int               xfers = 0;
    int               oob = 0;

    pixel_stream_scanner #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .PIX_W(PIX_W),
        .COL_W(COL_W),
        .ROW_W(ROW_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .continuous(continuous),
        .rom_row   (rom_row),
        .rom_col   (rom_col),
        .rom_data  (rom_data),
        .pixel_out (pixel_out),
        .pix_row   (pix_row),
        .pix_col   (pix_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sof       (sof),
        .eol       (eol),
        .eof       (eof),
        .busy      (busy),
        .frame_done(frame_done)
`ifdef SCAN_CHECKSUM_EN
        ,
        .frame_sum (frame_sum)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [PIX_W-1:0] rom_val(input int r, input int c, input logic [PIX_W-1:0] ofs);
        return PIX_W'(r * IMG_W + c) + ofs;
    endfunction

    // Synchronous ROM: one cycle of read latency.
    always @(posedge clk) rom_data <= rom_val(int'(rom_row), int'(rom_col), rom_ofs);

    always @(negedge clk)
        if (!rst && (int'(rom_row) >= IMG_H || int'(rom_col) >= IMG_W)) oob++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [PIX_W-1:0] ofs);
        exp_t e;
        logic [PIX_W-1:0] s;
        s = '0;
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                e.pix   = rom_val(r, c, ofs);
                e.row   = ROW_W'(r);
                e.col   = COL_W'(c);
                e.flags = {r == 0 && c == 0, c == IMG_W - 1, r == IMG_H - 1 && c == IMG_W - 1};
                s       = s ^ e.pix;
                exp_q.push_back(e);
            end
        sum_q.push_back(s);
    endtask

    // Score the transfer happening at the coming edge, then advance one cycle.
    task automatic step();
        exp_t e;
        if (out_valid && out_ready) begin
            xfers++;
            if (exp_q.size() == 0) chk("extra_xfer", 32'(exp_q.size()), 1);
            else begin
                e = exp_q.pop_front();
                chk("pixel", 32'(pixel_out), 32'(e.pix));
                chk("coord", {pix_row, pix_col}, {e.row, e.col});
                chk("flags", {sof, eol, eof}, 32'(e.flags));
            end
        end
        if (frame_done) begin
            fd_count++;
`ifdef SCAN_CHECKSUM_EN
            if (sum_q.size() > 0) chk("frame_sum", 32'(frame_sum), 32'(sum_q.pop_front()));
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    int n;
    int fd_base;
    int stalled;
    logic [PIX_W-1:0] held_pix;
    logic [ROW_W-1:0] held_row;
    logic [COL_W-1:0] held_col;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {pixel_out, pix_row, pix_col, out_valid, sof, eol, eof, busy, frame_done}, 0);
        chk("reset_addr", {rom_row, rom_col}, 0);
`ifdef SCAN_CHECKSUM_EN
        chk("reset_sum", 32'(frame_sum), 0);
`endif
        rst = 1'b0;
        step();

        // Single frame, latency, back-to-back transfers, done then idle
        rom_ofs = '0;
        push_frame(rom_ofs);
        pulse_start();
        chk("lat_c1_valid", out_valid, 0);
        chk("busy_run", busy, 1);
        step();
        chk("lat_c2_valid", out_valid, 0);
        step();
        for (int i = 0; i < IMG_W * IMG_H; i++) begin
            chk("valid_consec", out_valid, 1);
            step();
        end
        chk("queue_empty1", 32'(exp_q.size()), 0);
        chk("frame_done_pulse", frame_done, 1);
        chk("idle_after_eof", {busy, out_valid}, 0);
        step();
        chk("frame_done_one", frame_done, 0);
        chk("fd_count1", fd_count, 1);

        // Stall at (1,2) for five cycles
        rom_ofs = 12'h5A0;
        push_frame(rom_ofs);
        fd_base = fd_count;
        stalled = 0;
        n = 0;
        pulse_start();
        while (exp_q.size() > 0 && n < 80) begin
            if (stalled == 0 && out_valid && pix_row == 2'd1 && pix_col == 3'd2) begin
                stalled  = 1;
                held_pix = pixel_out;
                held_row = pix_row;
                held_col = pix_col;
                out_ready = 1'b0;
                repeat (5) begin
                    step();
                    chk("stall_hold", {out_valid, pixel_out, pix_row, pix_col}, {1'b1, held_pix, held_row, held_col});
                end
                out_ready = 1'b1;
            end
            step();
            n++;
        end
        chk("stall_seen", stalled, 1);
        chk("queue_empty2", 32'(exp_q.size()), 0);
        step();
        chk("fd_count2", fd_count - fd_base, 1);
        chk("idle2", busy, 0);

        // Continuous: two frames, mode dropped mid-way through the second
        rom_ofs = 12'h0A0;
        push_frame(rom_ofs);
        push_frame(rom_ofs);
        fd_base = fd_count;
        xfers = 0;
        continuous = 1'b1;
        pulse_start();
        step();
        step();
        for (int i = 0; i < 2 * IMG_W * IMG_H; i++) begin
            chk("cont_no_gap", out_valid, 1);
            if (xfers >= 14) continuous = 1'b0;
            step();
        end
        chk("queue_empty3", 32'(exp_q.size()), 0);
        chk("cont_idle", busy, 0);
        step();
        chk("fd_count3", fd_count - fd_base, 2);

        // Reset at pixel (1,1)
        rom_ofs = 12'h300;
        push_frame(rom_ofs);
        fd_base = fd_count;
        n = 0;
        pulse_start();
        while (!(out_valid && pix_row == 2'd1 && pix_col == 3'd1) && n < 40) begin
            step();
            n++;
        end
        chk("reached_1_1", {out_valid, pix_row, pix_col}, {1'b1, 2'd1, 3'd1});
        rst = 1'b1;
        #1;
        chk("async_reset", {pixel_out, pix_row, pix_col, out_valid, sof, eol, eof, busy, frame_done}, 0);
        exp_q.delete();
        sum_q.delete();
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("no_done_on_reset", fd_count - fd_base, 0);
        chk("idle_after_reset", {busy, out_valid}, 0);

        // Fresh frame after reset, with a Start pulse during RUN
        rom_ofs = 12'h7C0;
        push_frame(rom_ofs);
        fd_base = fd_count;
        n = 0;
        pulse_start();
        while (exp_q.size() > 0 && n < 60) begin
            start = (exp_q.size() == 6);
            step();
            n++;
        end
        start = 1'b0;
        chk("queue_empty5", 32'(exp_q.size()), 0);
        repeat (3) step();
        chk("fd_count5", fd_count - fd_base, 1);
        chk("idle5", {busy, out_valid}, 0);
        chk("addr_in_range", oob, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_stream_scanner.md
PIXEL_STREAM_SCANNER -- requirements
Module: pixel_stream_scanner

Interface
REQ-001 Parameter IMG_W, default 320: image width in pixels.
REQ-002 Parameter IMG_H, default 240: image height in pixels.
REQ-003 Parameter PIX_W, default 12: pixel data width.
REQ-004 Parameter COL_W, default 9, and ROW_W, default 8: coordinate widths, each SHALL be at least clog2 of the matching dimension.
REQ-005 Clock  in  1  single clock; all logic on its rising edge.
REQ-006 Reset  in  1  asynchronous, active-high reset.
REQ-007 Start  in  1  one-cycle request to begin scanning; sampled only in IDLE.
REQ-008 Continuous  in  1  1 = wrap to the next frame, 0 = stop after one frame; sampled at each frame's last address.
REQ-009 rom_row / rom_col  out  ROW_W / COL_W  ROM address; ROM returns data one cycle later.
REQ-010 rom_data  in  PIX_W  ROM read data.
REQ-011 pixel_out, pix_row, pix_col  out  PIX_W/ROW_W/COL_W  registered pixel and its coordinates.
REQ-012 out_valid  out  1 / out_ready  in  1  output handshake; a transfer occurs when both are high.
REQ-013 sof, eol, eof  out  1  qualified by out_valid: first pixel of the frame, last pixel of a row, last pixel of the frame.
REQ-014 busy  out  1 / frame_done  out  1  busy is high when not IDLE; frame_done is a one-cycle pulse.

Function
REQ-015 The state machine SHALL have states IDLE, RUN and DRAIN.
REQ-016 IDLE to RUN SHALL occur on Start; the counters SHALL start at (0,0).
REQ-017 In RUN, the column SHALL count 0..IMG_W-1, then wrap to 0 and increment the row; the row SHALL count 0..IMG_H-1. No out-of-range address SHALL ever be issued.
REQ-018 At address (IMG_H-1, IMG_W-1): if Continuous=1, the counters SHALL wrap to (0,0) and remain in RUN; otherwise the FSM SHALL enter DRAIN.
REQ-019 DRAIN SHALL move to IDLE in the cycle after the eof pixel transfers; frame_done SHALL pulse in that cycle, and also after each eof in continuous mode.
REQ-020 Pipeline: address stage, then a stage-1 register (valid, row, col), then an output register. First out_valid SHALL appear 2 cycles after Start.
REQ-021 stall = out_valid and not out_ready. During stall, the counters, stage-1 and the output SHALL hold, and the ROM address SHALL be driven from stage-1, so rom_data is correct on release.
REQ-022 Without stall, throughput SHALL be 1 pixel per cycle, with no bubbles across row or frame wraps.
REQ-023 Start outside IDLE SHALL be ignored; a change of Continuous mid-frame SHALL take effect at the next frame boundary only.
REQ-024 out_valid SHALL NOT drop without a transfer; pixel_out and coordinates SHALL be stable while stalled.

Reset
REQ-025 Reset SHALL force: state IDLE; counters, stage-1 and all outputs 0; out_valid, sof, eol, eof, busy and frame_done 0.
REQ-026 Reset mid-frame SHALL abandon the frame immediately, with no frame_done pulse; the next Start SHALL begin again at (0,0).

Configuration
REQ-027 Macro SCAN_CHECKSUM_EN defined: an extra output frame_sum [PIX_W-1:0] SHALL hold the XOR of all transferred pixels of the last completed frame, updated in the frame_done cycle and reset to 0.
REQ-028 Macro SCAN_CHECKSUM_EN undefined: no frame_sum port and no accumulator logic.

Structure
REQ-029 The shared package yoda_ima_pkg SHALL hold the default IMG_W, IMG_H and PIX_W values and the FSM state encoding.
REQ-030 The row/column counter with its wrap and last-address flags SHALL be the sub-module scan_counter; the FSM, pipeline and handshake SHALL stay in the top module.

Verification
REQ-031 IMG_W=4, IMG_H=3, out_ready=1, Continuous=0, Start pulse -> 12 transfers (0,0)..(2,3) on consecutive cycles; sof on the 1st, eol on the 4th, 8th and 12th, eof on the 12th; then frame_done, then IDLE.
REQ-032 Same setup, out_ready low for 5 cycles at pixel (1,2) -> pixel_out and coordinates held; on release, data equals ROM[1][2]; no pixel lost or duplicated.
REQ-033 Continuous=1 for 2 frames -> pixel (0,0) follows (2,3) with no gap; sof is reasserted; frame_done pulses twice.
REQ-034 Reset asserted at pixel (1,1) -> all outputs 0 immediately; the next Start gives sof at (0,0).
REQ-035 Start pulsed during RUN -> no effect on the sequence.
REQ-036 SCAN_CHECKSUM_EN defined, ROM holding row*4+col -> frame_sum = XOR of 0..11 = 0x000 after frame_done.
